// File: rtl/rtc_menu_pkg.sv
// Shared types for the RTC menu controller.
//   state_t   : menu FSM states
//   btn_t     : single serviced button after priority encoding
//   btn_pick  : priority encoder Bcentro > Barriba > Babajo > Bizquierda > Bderecha
//   clog2     : ceil(log2(v)), used to size counters
package rtc_menu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    EDIT,
    WR_REQ,
    ALARM,
    CLR_REQ
  } state_t;

  typedef enum logic [2:0] {
    BTN_NONE,
    BTN_CENTRO,
    BTN_ARRIBA,
    BTN_ABAJO,
    BTN_IZQ,
    BTN_DER
  } btn_t;

  function automatic btn_t btn_pick(input logic c, input logic u, input logic d,
                                    input logic l, input logic r);
    if (c)      return BTN_CENTRO;
    else if (u) return BTN_ARRIBA;
    else if (d) return BTN_ABAJO;
    else if (l) return BTN_IZQ;
    else if (r) return BTN_DER;
    else        return BTN_NONE;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned res;
    res = 0;
    for (int unsigned p = 1; p < v; p = p << 1) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/rtc_menu_fsm_n_if.sv
// Signal bundle between the menu FSM, the button block and the RTC bus
// controller.
//   master : button/bus side (drives buttons, IRQ, FRW; reads results)
//   slave  : menu FSM side
interface rtc_menu_fsm_n_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CUR_W  = 4
);
  logic              Barriba;
  logic              Babajo;
  logic              Bizquierda;
  logic              Bderecha;
  logic              Bcentro;
  logic              IRQ;
  logic              FRW;
  logic [ADDR_W-1:0] Dir;
  logic              Acceso;
  logic              Mod;
  logic              Alarma;
  logic              Edit;
  logic              Numup;
  logic              Numdown;
  logic [CUR_W-1:0]  Punt;

  modport master (
    output Barriba, Babajo, Bizquierda, Bderecha, Bcentro, IRQ, FRW,
    input  Dir, Acceso, Mod, Alarma, Edit, Numup, Numdown, Punt
  );

  modport slave (
    input  Barriba, Babajo, Bizquierda, Bderecha, Bcentro, IRQ, FRW,
    output Dir, Acceso, Mod, Alarma, Edit, Numup, Numdown, Punt
  );
endinterface

// File: rtl/rtc_sweep_seq.sv
// Issues len consecutive RTC transactions starting at base.
//   start        : one-cycle pulse, captures base/len/mode and raises req
//   frw          : bus done strobe, only honoured while req is high
//   addr/req/wr  : current address, request (Acceso), direction (Mod)
//   done         : combinational, high on the FRW of the last transaction
// req drops for one cycle after every FRW, then re-raises for the next field.
module rtc_sweep_seq
  import rtc_menu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       LEN_W    = 4,
  parameter logic [ADDR_W-1:0] RST_BASE = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              mode,
  input  logic              frw,
  output logic [ADDR_W-1:0] addr,
  output logic              req,
  output logic              wr,
  output logic              done
);

  logic [ADDR_W-1:0] base_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  idx;
  logic              mode_r;
  logic              active;
  logic              last;

  assign last = (idx == len_r - LEN_W'(1));
  assign done = req & frw & last;
  assign addr = base_r + ADDR_W'(idx);
  assign wr   = mode_r;

  always_ff @(posedge CLK) begin
    if (RST) begin
      base_r <= RST_BASE;
      len_r  <= '0;
      idx    <= '0;
      mode_r <= 1'b0;
      active <= 1'b0;
      req    <= 1'b0;
    end else if (start) begin
      base_r <= base;
      len_r  <= len;
      idx    <= '0;
      mode_r <= mode;
      active <= 1'b1;
      req    <= 1'b1;
    end else if (req && frw) begin
      req <= 1'b0;
      if (last) active <= 1'b0;
      else      idx    <= idx + LEN_W'(1);
    end else if (active) begin
      req <= 1'b1;
    end
  end

endmodule

// File: rtl/rtc_menu_fsm_n.sv
// Menu FSM of the RTC controller, parametrised on the number of fields.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : buttons, IRQ, FRW in; Dir/Acceso/Mod bus request, Alarma,
//              Edit, Numup/Numdown pulses and Punt cursor out
// Periodic read sweeps, edit mode with cursor and write-back sweep, and
// alarm acknowledge with a flag-clear write.
module rtc_menu_fsm_n
  import rtc_menu_pkg::*;
#(
  parameter int unsigned       N_FIELDS       = 7,
  parameter int unsigned       ADDR_W         = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 8'h21,
  parameter logic [ADDR_W-1:0] ALARM_CLR_ADDR = 8'h44,
  parameter int unsigned       REFRESH_CYC    = 1000,
  parameter int unsigned       TIMEOUT_CYC    = 100000,
  parameter int unsigned       CUR_W          = 4
) (
  input logic              CLK,
  input logic              RST,
  rtc_menu_fsm_n_if.slave  bus
);

  localparam int unsigned REF_W = clog2(REFRESH_CYC) + 1;
  localparam int unsigned TO_W  = clog2(TIMEOUT_CYC) + 1;
  localparam int unsigned LEN_W = clog2(N_FIELDS) + 1;

  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CUR_W-1:0] PUNT_LAST = CUR_W'(N_FIELDS - 1);

  state_t            state, state_n;
  btn_t              btn;
  logic [CUR_W-1:0]  punt, punt_n;
  logic              numup, numup_n;
  logic              numdown, numdown_n;
  logic [REF_W-1:0]  ref_cnt, ref_n;
  logic [TO_W-1:0]   to_cnt, to_n;
  logic              irq_l, irq_n;

  logic              sw_start;
  logic [ADDR_W-1:0] sw_base;
  logic [LEN_W-1:0]  sw_len;
  logic              sw_mode;
  logic              sw_done;

  rtc_sweep_seq #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .RST_BASE (BASE_ADDR)
  ) u_sweep (
    .CLK   (CLK),
    .RST   (RST),
    .start (sw_start),
    .base  (sw_base),
    .len   (sw_len),
    .mode  (sw_mode),
    .frw   (bus.FRW),
    .addr  (bus.Dir),
    .req   (bus.Acceso),
    .wr    (bus.Mod),
    .done  (sw_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      punt    <= '0;
      numup   <= 1'b0;
      numdown <= 1'b0;
      ref_cnt <= '0;
      to_cnt  <= '0;
      irq_l   <= 1'b0;
    end else begin
      state   <= state_n;
      punt    <= punt_n;
      numup   <= numup_n;
      numdown <= numdown_n;
      ref_cnt <= ref_n;
      to_cnt  <= to_n;
      irq_l   <= irq_n;
    end
  end

  always_comb begin
    state_n   = state;
    punt_n    = punt;
    numup_n   = 1'b0;
    numdown_n = 1'b0;
    ref_n     = ref_cnt;
    to_n      = to_cnt;
    irq_n     = irq_l | bus.IRQ;
    sw_start  = 1'b0;
    sw_base   = BASE_ADDR;
    sw_len    = LEN_W'(N_FIELDS);
    sw_mode   = 1'b0;
    btn       = btn_pick(bus.Bcentro, bus.Barriba, bus.Babajo,
                         bus.Bizquierda, bus.Bderecha);
    case (state)
      IDLE: begin
        // Refresh counter only advances when nothing else claims the cycle.
        if (bus.Bcentro) begin
          state_n = EDIT;
          punt_n  = '0;
          to_n    = '0;
        end else if (irq_l) begin
          state_n = ALARM;
        end else if (ref_cnt == REF_LAST) begin
          state_n  = RD_REQ;
          sw_start = 1'b1;
        end else begin
          ref_n = ref_cnt + REF_W'(1);
        end
      end
      RD_REQ: begin
        if (sw_done) begin
          state_n = IDLE;
          ref_n   = '0;
        end
      end
      EDIT: begin
        if (btn != BTN_NONE) to_n = '0;
        case (btn)
          BTN_CENTRO: begin
            state_n  = WR_REQ;
            sw_start = 1'b1;
            sw_mode  = 1'b1;
          end
          BTN_ARRIBA: numup_n   = 1'b1;
          BTN_ABAJO:  numdown_n = 1'b1;
          BTN_IZQ:    punt_n = (punt == '0) ? PUNT_LAST : punt - CUR_W'(1);
          BTN_DER:    punt_n = (punt == PUNT_LAST) ? '0 : punt + CUR_W'(1);
          default: begin
            if (to_cnt == TO_LAST) state_n = IDLE;
            else                   to_n    = to_cnt + TO_W'(1);
          end
        endcase
      end
      WR_REQ: begin
        if (sw_done) begin
          state_n = IDLE;
          punt_n  = '0;
        end
      end
      ALARM: begin
        if (bus.Bcentro) begin
          state_n  = CLR_REQ;
          sw_start = 1'b1;
          sw_base  = ALARM_CLR_ADDR;
          sw_len   = LEN_W'(1);
          sw_mode  = 1'b1;
          irq_n    = 1'b0;
        end
      end
      CLR_REQ: begin
        if (sw_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.Edit    = (state == EDIT) || (state == WR_REQ);
  assign bus.Alarma  = (state == ALARM) || (state == CLR_REQ);
  assign bus.Numup   = numup;
  assign bus.Numdown = numdown;
  assign bus.Punt    = punt;

endmodule

// File: tb/tb_rtc_menu_fsm_n.sv
module tb_rtc_menu_fsm_n;

  localparam int NF      = 3;
  localparam int REFRESH = 4;
  localparam int TMO     = 10;
  localparam int BASE    = 'h21;
  localparam int CLRA    = 'h44;

  // button patterns {centro, arriba, abajo, izquierda, derecha}
  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] BC = 5'b10000;
  localparam logic [4:0] BU = 5'b01000;
  localparam logic [4:0] BD = 5'b00100;
  localparam logic [4:0] BL = 5'b00010;
  localparam logic [4:0] BR = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rtc_menu_fsm_n_if #(.ADDR_W(8), .CUR_W(4)) bus ();

  rtc_menu_fsm_n #(
    .N_FIELDS       (NF),
    .ADDR_W         (8),
    .BASE_ADDR      (8'h21),
    .ALARM_CLR_ADDR (8'h44),
    .REFRESH_CYC    (REFRESH),
    .TIMEOUT_CYC    (TMO),
    .CUR_W          (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- behavioural reference model ----------------
  // where: 0 menu idle, 1 editing, 2 alarm shown; kind: active sweep
  // (0 none, 1 read, 2 write-back, 3 alarm clear)
  int m_req, m_dir, m_mod, m_alarm, m_edit, m_up, m_dn, m_punt;
  int m_kind, m_base, m_len, m_field, m_where, m_irq, m_idle, m_quiet;

  task automatic begin_sweep(input int kind, input int base, input int len, input int mode);
    m_kind = kind; m_base = base; m_len = len; m_field = 0; m_req = 1; m_mod = mode;
  endtask

  task automatic model_step(input logic r, input logic [4:0] b, input logic irq, input logic frw);
    bit clr_entry;
    clr_entry = 0;
    if (r) begin
      m_req = 0; m_base = BASE; m_len = NF; m_field = 0; m_mod = 0; m_alarm = 0;
      m_edit = 0; m_up = 0; m_dn = 0; m_punt = 0; m_kind = 0; m_where = 0;
      m_irq = 0; m_idle = 0; m_quiet = 0; m_dir = BASE;
      return;
    end
    m_up = 0; m_dn = 0;
    if (m_kind != 0) begin
      if (m_req != 0 && frw) begin
        m_req = 0;
        if (m_field == m_len - 1) begin
          if (m_kind == 1) m_idle = 0;
          if (m_kind == 2) begin m_edit = 0; m_punt = 0; end
          if (m_kind == 3) m_alarm = 0;
          m_kind = 0;
        end else m_field++;
      end else if (m_req == 0) m_req = 1;
    end else if (m_where == 0) begin
      if (b[4]) begin m_where = 1; m_edit = 1; m_punt = 0; m_quiet = 0; end
      else if (m_irq != 0) begin m_where = 2; m_alarm = 1; end
      else begin
        m_idle++;
        if (m_idle == REFRESH) begin_sweep(1, BASE, NF, 0);
      end
    end else if (m_where == 1) begin
      if (b != 0) begin
        m_quiet = 0;
        if (b[4]) begin m_where = 0; begin_sweep(2, BASE, NF, 1); end
        else if (b[3]) m_up = 1;
        else if (b[2]) m_dn = 1;
        else if (b[1]) m_punt = (m_punt + NF - 1) % NF;
        else m_punt = (m_punt + 1) % NF;
      end else begin
        m_quiet++;
        if (m_quiet == TMO) begin m_where = 0; m_edit = 0; end
      end
    end else begin
      if (b[4]) begin m_where = 0; begin_sweep(3, CLRA, 1, 1); clr_entry = 1; end
    end
    m_irq = clr_entry ? 0 : (m_irq | int'(irq));
    m_dir = (m_base + m_field) % 256;
  endtask

  // ---------------- driving and checking ----------------
  task automatic cycle(input logic r, input logic [4:0] b, input logic irq, input logic frw);
    rst = r;
    {bus.Bcentro, bus.Barriba, bus.Babajo, bus.Bizquierda, bus.Bderecha} = b;
    bus.IRQ = irq;
    bus.FRW = frw;
    @(posedge clk);
    #1;
    model_step(r, b, irq, frw);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic acc, input logic [7:0] dir,
                         input logic mod, input logic alm, input logic edt,
                         input logic up, input logic dn, input logic [3:0] punt,
                         input bit with_dir);
    chk({tag, ".Acceso"},  bus.Acceso,  acc);
    chk({tag, ".Alarma"},  bus.Alarma,  alm);
    chk({tag, ".Edit"},    bus.Edit,    edt);
    chk({tag, ".Numup"},   bus.Numup,   up);
    chk({tag, ".Numdown"}, bus.Numdown, dn);
    chk({tag, ".Punt"},    bus.Punt,    punt);
    if (with_dir) begin
      chk({tag, ".Dir"}, bus.Dir, dir);
      chk({tag, ".Mod"}, bus.Mod, mod);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [4:0] b;
    logic       irq, frw;
    logic       acc;
    logic [7:0] dir;
    logic       mod, alm, edt, up, dn;
    logic [3:0] punt;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [4:0] b, input logic irq,
                             input logic frw, input logic acc, input logic [7:0] dir,
                             input logic mod, input logic alm, input logic edt,
                             input logic up, input logic dn, input logic [3:0] punt);
    vec_t x;
    x.rst = r; x.b = b; x.irq = irq; x.frw = frw; x.acc = acc; x.dir = dir;
    x.mod = mod; x.alm = alm; x.edt = edt; x.up = up; x.dn = dn; x.punt = punt;
    return x;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic found;
    logic [4:0] rb;
    logic ri, rf, rr;
    int unsigned p;

    bus.Barriba = 0; bus.Babajo = 0; bus.Bizquierda = 0; bus.Bderecha = 0;
    bus.Bcentro = 0; bus.IRQ = 0; bus.FRW = 0;

    //             rst b   irq frw | acc dir    mod alm edt up dn punt
    // reset, then refresh sweep 0x21..0x23 with FRW two cycles after request
    tbl.push_back(v(1, NO, 0, 0,  0, 8'h21, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, NO, 0, 0,  0, 8'h21, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  1, 8'h21, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  1, 8'h21, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  1, 8'h22, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  1, 8'h22, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, BU, 0, 0,  1, 8'h23, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, BC, 0, 0,  1, 8'h23, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    // stray FRW while idle, then four idle cycles to the next sweep
    tbl.push_back(v(0, NO, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  1, 8'h21, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  1, 8'h22, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  1, 8'h23, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    // edit: cursor wraps, up/down pulses, up beats right, write-back
    tbl.push_back(v(0, BC, 0, 0,  0, 8'h00, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, BL, 0, 0,  0, 8'h00, 0, 0, 1, 0, 0, 2));
    tbl.push_back(v(0, BR, 0, 0,  0, 8'h00, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, BU, 0, 0,  0, 8'h00, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  0, 8'h00, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, BU|BR, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(0, BD, 0, 0,  0, 8'h00, 0, 0, 1, 0, 1, 0));
    tbl.push_back(v(0, BR, 0, 0,  0, 8'h00, 0, 0, 1, 0, 0, 1));
    tbl.push_back(v(0, BC, 0, 0,  1, 8'h21, 1, 0, 1, 0, 0, 1));
    tbl.push_back(v(0, BL, 0, 1,  0, 8'h00, 1, 0, 1, 0, 0, 1));
    tbl.push_back(v(0, NO, 0, 0,  1, 8'h22, 1, 0, 1, 0, 0, 1));
    tbl.push_back(v(0, NO, 0, 1,  0, 8'h00, 1, 0, 1, 0, 0, 1));
    tbl.push_back(v(0, NO, 0, 0,  1, 8'h23, 1, 0, 1, 0, 0, 1));
    tbl.push_back(v(0, NO, 0, 1,  0, 8'h00, 1, 0, 0, 0, 0, 0));
    // IRQ during a read sweep is held until the sweep completes
    tbl.push_back(v(0, NO, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  1, 8'h21, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 1, 0,  1, 8'h21, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  1, 8'h22, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  1, 8'h23, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  0, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, BU, 0, 0,  0, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, BC, 0, 0,  1, 8'h44, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  1, 8'h44, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].b, tbl[i].irq, tbl[i].frw);
      chk_out($sformatf("tbl[%0d]", i), tbl[i].acc, tbl[i].dir, tbl[i].mod,
              tbl[i].alm, tbl[i].edt, tbl[i].up, tbl[i].dn, tbl[i].punt,
              tbl[i].acc || tbl[i].rst);
    end

    // edit inactivity timeout: ten quiet cycles return to idle, no write
    cycle(0, BC, 0, 0);
    chk_out("tmo.enter", 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k < TMO; k++) begin
      cycle(0, NO, 0, 0);
      chk_out($sformatf("tmo.q%0d", k), 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    end
    cycle(0, NO, 0, 0);
    chk_out("tmo.exit", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);

    // reset while a read of 0x22 is outstanding; late FRW must be ignored
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle(0, NO, 0, bus.Acceso && bus.Dir == 8'h21);
      found = bus.Acceso && bus.Dir == 8'h22;
    end
    chk("rstmid.reach", found, 1);
    cycle(1, NO, 0, 0);
    chk_out("rstmid.rst", 0, 8'h21, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, NO, 0, 1);
    chk_out("rstmid.lateFRW", 0, 8'h21, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, NO, 0, 0);
    chk_out("rstmid.idle2", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, NO, 0, 0);
    chk_out("rstmid.idle3", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, NO, 0, 0);
    chk_out("rstmid.sweep", 1, 8'h21, 0, 0, 0, 0, 0, 0, 1);

    // randomized traffic against the reference model
    cycle(1, NO, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      p  = $urandom_range(0, 99);
      rb = NO;
      if (p < 20)      rb = 5'b00001 << $urandom_range(0, 4);
      else if (p < 24) rb = 5'($urandom);
      ri = ($urandom_range(0, 99) < 3);
      rf = ($urandom_range(0, 99) < 45);
      rr = ($urandom_range(0, 999) < 3);
      cycle(rr, rb, ri, rf);
      chk_out($sformatf("rnd[%0d]", i), m_req[0], 8'(m_dir), m_mod[0], m_alarm[0],
              m_edit[0], m_up[0], m_dn[0], 4'(m_punt), m_req != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
